// File: rtl/float_mul_arb_if.sv
// Bundle between the float_mul sharing arbiter, its requesters and the shared float_mul.
// master is the arbiter's view; slave is the mirrored view of the surrounding datapath.
interface float_mul_arb_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*32-1:0] a_in;
  logic [NREQ*32-1:0] b_in;
  logic [NREQ-1:0]    done;
  logic [31:0]        res_out;
  logic               err;
  logic               mul_start;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [31:0]        mul_out;
  logic               mul_ready;

  modport master (
    input  req, a_in, b_in, mul_out, mul_ready,
    output done, res_out, err, mul_start, mul_a, mul_b
  );

  modport slave (
    output req, a_in, b_in, mul_out, mul_ready,
    input  done, res_out, err, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/float_mul_arb.sv
// Round-robin arbiter sharing one float_mul among NREQ requesters; a watchdog
// turns a hung multiply into a quiet-NaN result plus a sticky error flag.
module float_mul_arb #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input  logic            clk,
  input  logic            rst,
  float_mul_arb_if.master bus
);

  localparam int unsigned IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] QuietNan = 32'h7FC0_0000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [31:0]     res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            ready_q;

  logic [IW-1:0]   grant;
  logic            grant_vld;
  logic [31:0]     sel_a, sel_b;
  logic            ready_edge;
  logic            cnt_expired;

  // A level left high from the previous operation must not complete this one.
  assign ready_edge  = bus.mul_ready & ~ready_q;
  assign cnt_expired = (cnt_q == CW'(TIMEOUT - 1));

  // First requester at or above the rotating pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && bus.req[(32'(ptr_q) + i) % NREQ]) begin
        grant_vld = 1'b1;
        grant     = IW'((32'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == grant) begin
        sel_a = bus.a_in[i*32 +: 32];
        sel_b = bus.b_in[i*32 +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_vld) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (ready_edge || cnt_expired) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          owner_d = grant;
          mul_a_d = sel_a;
          mul_b_d = sel_b;
        end
      end
      StIssue: cnt_d = '0;
      StWait: begin
        if (ready_edge) begin
          res_d = bus.mul_out;
        end else if (cnt_expired) begin
          err_d = 1'b1;
          res_d = QuietNan;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= bus.mul_ready;
    end
  end

  // Outputs
  always_comb begin
    bus.done = '0;
    if (state_q == StDone) begin
      bus.done[owner_q] = 1'b1;
    end
    bus.mul_start = (state_q == StIssue);
  end

  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.res_out = res_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_float_mul_arb.sv
// Directed bench for float_mul_arb with a behavioural float_mul whose latency,
// stale-ready hold and hang behaviour are set per scenario.
module tb_float_mul_arb;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CW      = 7;

  localparam logic [31:0] F_N1  = 32'hBF80_0000;
  localparam logic [31:0] F_1P5 = 32'h3FC0_0000;
  localparam logic [31:0] F_2   = 32'h4000_0000;
  localparam logic [31:0] F_3   = 32'h4040_0000;
  localparam logic [31:0] F_4   = 32'h4080_0000;
  localparam logic [31:0] F_6   = 32'h40C0_0000;
  localparam logic [31:0] F_M4  = 32'hC080_0000;
  localparam logic [31:0] QNAN  = 32'h7FC0_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   start_cnt;
  int   start_cyc;
  int   lat;
  int   hold;
  bit   hang;

  float_mul_arb_if #(.NREQ(NREQ)) bus ();

  float_mul_arb #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mul_lookup(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {F_2, F_3}:   return F_6;
      {F_1P5, F_2}: return F_3;
      {F_2, F_2}:   return F_4;
      {F_N1, F_4}:  return F_M4;
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  // float_mul model: on start, keep any old ready level for `hold` cycles,
  // drop it, then raise it with the product `lat` cycles later.
  initial begin
    bus.mul_ready = 1'b0;
    bus.mul_out   = '0;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b1 && bus.mul_start === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
        if (hang) begin
          bus.mul_ready = 1'b0;
        end else begin
          repeat (hold) begin @(posedge clk); #1; end
          bus.mul_ready = 1'b0;
          repeat (lat) begin @(posedge clk); #1; end
          bus.mul_out   = mul_lookup(bus.mul_a, bus.mul_b);
          bus.mul_ready = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns done=0 and at=-1 if no done pulse appears within the budget.
  task automatic wait_done(input int budget, output logic [NREQ-1:0] d, output int at);
    d  = '0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.done !== '0) begin
        d  = bus.done;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    hang     = 1'b0;
    hold     = 0;
    lat      = 4;
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.done !== 3'b000) begin
      n_bad++; $display("FAIL reset_done got %b want 000", bus.done); end
    n_cmp++; if (bus.res_out !== 32'h0) begin
      n_bad++; $display("FAIL reset_res got %h want 0", bus.res_out); end
    n_cmp++; if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL reset_err got %b want 0", bus.err); end
    n_cmp++; if (bus.mul_start !== 1'b0) begin
      n_bad++; $display("FAIL reset_start got %b want 0", bus.mul_start); end
    n_cmp++; if (bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin
      n_bad++; $display("FAIL reset_ops got %h/%h want 0/0", bus.mul_a, bus.mul_b); end
    step(2);
    rst = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    logic [NREQ-1:0] d;
    int at;
    int s0;
    bus.a_in = {64'h0, F_2};
    bus.b_in = {64'h0, F_3};
    s0       = start_cnt;
    bus.req  = 3'b001;
    wait_done(40, d, at);
    bus.req = '0;
    n_cmp++; if (d !== 3'b001) begin
      n_bad++; $display("FAIL single_done got %b want 001", d); end
    n_cmp++; if (bus.res_out !== F_6) begin
      n_bad++; $display("FAIL single_res got %h want %h", bus.res_out, F_6); end
    n_cmp++; if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL single_err got %b want 0", bus.err); end
    n_cmp++; if (at - start_cyc != 5) begin
      n_bad++; $display("FAIL single_latency got %0d want 5", at - start_cyc); end
    n_cmp++; if (bus.mul_a !== F_2 || bus.mul_b !== F_3) begin
      n_bad++; $display("FAIL single_ops got %h/%h want %h/%h", bus.mul_a, bus.mul_b, F_2, F_3);
    end
    step(1);
    n_cmp++; if (bus.done !== 3'b000) begin
      n_bad++; $display("FAIL single_pulse got %b want 000", bus.done); end
    step(3);
    n_cmp++; if (start_cnt - s0 != 1) begin
      n_bad++; $display("FAIL single_starts got %0d want 1", start_cnt - s0); end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] d;
    logic [NREQ-1:0] exp_d [3];
    logic [31:0]     exp_r [3];
    int at;
    int s0;
    exp_d = '{3'b001, 3'b010, 3'b100};
    exp_r = '{F_3, F_4, F_M4};
    do_reset();
    bus.a_in = {F_N1, F_2, F_1P5};
    bus.b_in = {F_4, F_2, F_2};
    s0       = start_cnt;
    bus.req  = 3'b111;
    for (int k = 0; k < 3; k++) begin
      wait_done(40, d, at);
      bus.req = bus.req & ~d;
      n_cmp++; if (d !== exp_d[k]) begin
        n_bad++; $display("FAIL contention_done[%0d] got %b want %b", k, d, exp_d[k]); end
      n_cmp++; if (bus.res_out !== exp_r[k]) begin
        n_bad++; $display("FAIL contention_res[%0d] got %h want %h", k, bus.res_out, exp_r[k]);
      end
    end
    bus.req = '0;
    step(4);
    n_cmp++; if (start_cnt - s0 != 3) begin
      n_bad++; $display("FAIL contention_starts got %0d want 3", start_cnt - s0); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] d;
    logic [NREQ-1:0] exp_d [4];
    logic [31:0]     exp_r [4];
    int at;
    exp_d = '{3'b001, 3'b100, 3'b001, 3'b100};
    exp_r = '{F_6, F_M4, F_6, F_M4};
    bus.a_in = {F_N1, 32'h0, F_2};
    bus.b_in = {F_4, 32'h0, F_3};
    bus.req  = 3'b101;
    for (int k = 0; k < 4; k++) begin
      wait_done(40, d, at);
      if (k == 3) bus.req = '0;
      n_cmp++; if (d !== exp_d[k]) begin
        n_bad++; $display("FAIL fairness_done[%0d] got %b want %b", k, d, exp_d[k]); end
      n_cmp++; if (bus.res_out !== exp_r[k]) begin
        n_bad++; $display("FAIL fairness_res[%0d] got %h want %h", k, bus.res_out, exp_r[k]); end
    end
    step(2);
  endtask

  task automatic test_stale();
    logic [NREQ-1:0] d;
    int at;
    hold     = 3;
    lat      = 2;
    bus.a_in = {32'h0, F_2, 32'h0};
    bus.b_in = {32'h0, F_2, 32'h0};
    bus.req  = 3'b010;
    wait_done(40, d, at);
    bus.req = '0;
    n_cmp++; if (d !== 3'b010) begin
      n_bad++; $display("FAIL stale_done got %b want 010", d); end
    n_cmp++; if (at - start_cyc != 6) begin
      n_bad++; $display("FAIL stale_latency got %0d want 6", at - start_cyc); end
    n_cmp++; if (bus.res_out !== F_4) begin
      n_bad++; $display("FAIL stale_res got %h want %h", bus.res_out, F_4); end
    hold = 0;
    step(2);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] d;
    int at;
    hang     = 1'b1;
    bus.a_in = {64'h0, F_2};
    bus.b_in = {64'h0, F_3};
    bus.req  = 3'b001;
    wait_done(200, d, at);
    bus.req = '0;
    n_cmp++; if (d !== 3'b001) begin
      n_bad++; $display("FAIL timeout_done got %b want 001", d); end
    n_cmp++; if (at - start_cyc != 65) begin
      n_bad++; $display("FAIL timeout_latency got %0d want 65", at - start_cyc); end
    n_cmp++; if (bus.res_out !== QNAN) begin
      n_bad++; $display("FAIL timeout_res got %h want %h", bus.res_out, QNAN); end
    n_cmp++; if (bus.err !== 1'b1) begin
      n_bad++; $display("FAIL timeout_err got %b want 1", bus.err); end
    step(5);
    hang     = 1'b0;
    lat      = 4;
    bus.a_in = {32'h0, F_2, 32'h0};
    bus.b_in = {32'h0, F_2, 32'h0};
    bus.req  = 3'b010;
    wait_done(40, d, at);
    bus.req = '0;
    n_cmp++; if (d !== 3'b010) begin
      n_bad++; $display("FAIL after_timeout_done got %b want 010", d); end
    n_cmp++; if (bus.res_out !== F_4) begin
      n_bad++; $display("FAIL after_timeout_res got %h want %h", bus.res_out, F_4); end
    n_cmp++; if (bus.err !== 1'b1) begin
      n_bad++; $display("FAIL err_sticky got %b want 1", bus.err); end
    step(2);
  endtask

  task automatic test_reset_wait();
    logic [NREQ-1:0] d;
    int at;
    bit seen;
    hang     = 1'b1;
    bus.a_in = {F_2, 64'h0};
    bus.b_in = {F_3, 64'h0};
    bus.req  = 3'b100;
    seen     = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1);
      if (bus.mul_start === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin
      n_bad++; $display("FAIL rstwait_start got none want pulse"); end
    step(2);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.done !== 3'b000 || bus.mul_start !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_outs got %b/%b want 000/0", bus.done, bus.mul_start); end
    n_cmp++; if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL rstwait_err got %b want 0", bus.err); end
    n_cmp++; if (bus.res_out !== 32'h0) begin
      n_bad++; $display("FAIL rstwait_res got %h want 0", bus.res_out); end
    bus.req = '0;
    step(2);
    rst = 1'b1;
    step(2);
    n_cmp++; if (bus.mul_start !== 1'b0 || bus.done !== 3'b000) begin
      n_bad++; $display("FAIL rstwait_idle got %b/%b want 0/000", bus.mul_start, bus.done); end
    // Pointer back at 0 means requester 1 wins over requester 2.
    hang     = 1'b0;
    lat      = 2;
    bus.a_in = {F_N1, F_2, 32'h0};
    bus.b_in = {F_4, F_2, 32'h0};
    bus.req  = 3'b110;
    wait_done(40, d, at);
    bus.req = bus.req & ~d;
    n_cmp++; if (d !== 3'b010) begin
      n_bad++; $display("FAIL rstwait_ptr got %b want 010", d); end
    n_cmp++; if (bus.res_out !== F_4) begin
      n_bad++; $display("FAIL rstwait_res1 got %h want %h", bus.res_out, F_4); end
    wait_done(40, d, at);
    bus.req = '0;
    n_cmp++; if (d !== 3'b100) begin
      n_bad++; $display("FAIL rstwait_next got %b want 100", d); end
    n_cmp++; if (bus.res_out !== F_M4) begin
      n_bad++; $display("FAIL rstwait_res2 got %h want %h", bus.res_out, F_M4); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_stale();
    test_timeout();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/float_mul_arb.md
Name: float_mul_arb

Overview:
- Round-robin arbiter and sequencer that shares one float_mul instance among NREQ requesters in the InvSqrt datapath (e.g. the y*y, x*y² and Newton-update multiplies).
- Latches the winner's operands, pulses float_mul start, and waits for a rising edge of ready.
- Returns the product to the owning requester with a one-cycle done pulse.
- A watchdog aborts a hung multiply so the datapath never deadlocks.

Parameters:
- NREQ, 3, number of requesters (2..8)
- TIMEOUT, 64, max cycles waited in WAIT before abort (≥8)
- CW, 7, timeout counter width; must hold TIMEOUT

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req  in  NREQ  per-requester request level
- a_in  in  NREQ*32  packed operand A; requester i uses bits [32i+31:32i]
- b_in  in  NREQ*32  packed operand B, same packing
- done  out  NREQ  one-cycle completion pulse, one-hot
- res_out  out  32  product (IEEE-754 single); valid while any done bit is high
- err  out  1  sticky timeout flag
- mul_start  out  1  to float_mul start
- mul_a  out  32  to float_mul operand 1
- mul_b  out  32  to float_mul operand 2
- mul_out  in  32  from float_mul result
- mul_ready  in  1  from float_mul ready

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, done=0, res_out=0, err=0
  - mul_start=0, mul_a=0, mul_b=0
  - rr pointer=0, owner=0, ready_q=0, timeout counter=0
- ready_q is mul_ready registered every cycle. A ready edge is mul_ready & ~ready_q.
- States:
  - IDLE:
    - if req≠0, pick the first set bit scanning from the rr pointer upward with wrap.
    - Latch owner, mul_a=a_in[owner], mul_b=b_in[owner]; go to ISSUE.
    - If req=0, stay in IDLE.
  - ISSUE: mul_start=1 for exactly this cycle; clear the counter; go to WAIT.
  - WAIT:
    - ready edge → res_out=mul_out; go to DONE.
    - Otherwise the counter increments.
    - counter==TIMEOUT-1 without an edge → err=1, res_out=32'h7FC00000 (quiet NaN); go to DONE.
  - DONE:
    - done[owner]=1 for this cycle only.
    - rr pointer=(owner+1) mod NREQ; go to IDLE.
- Latency:
  - req sampled in IDLE at cycle 0; mul_start high in cycle 1.
  - If the first ready edge is seen in cycle k, done is high in cycle k+1.
  - Best-case turnaround is float_mul latency + 3 cycles.
- mul_a and mul_b stay stable from ISSUE until the next IDLE grant. float_mul may sample them at any point during the operation.
- mul_ready already high when entering WAIT (level left over from the previous op) is not an edge and is ignored. Only a fresh 0→1 transition completes the operation.
- Requesters hold req high with stable operands until done. Operands are latched at grant, so later changes have no effect.
- req dropped mid-operation: the operation completes and done is still pulsed; the requester ignores it.
- req still high in the cycle after done: treated as a new request. The rr pointer already gives the other requesters priority, so there is no starvation. With NREQ requesters, the worst-case wait is NREQ operations.
- Only one operation is in flight at a time. A new grant happens no earlier than the cycle after DONE.
- res_out holds its value until the next DONE update.
- err clears only on reset. Operation continues normally after a timeout.
- Reset asserted mid-operation:
  - All state clears immediately and no done is emitted.
  - mul_start drops at once.
  - The float_mul state is the integrator's responsibility; it shares the same reset.

Test Plan:
- Single request: req=001, A=0x40000000 (2.0), B=0x40400000 (3.0), float_mul latency 4 → one mul_start pulse; done=001 one cycle; res_out=0x40C00000 (6.0); err=0.
- Contention: req=111 held, pointer=0, operands 1.5×2.0, 2.0×2.0, −1.0×4.0 → done order 001, 010, 100; results 0x40400000, 0x40800000, 0xC0800000; exactly 3 mul_start pulses.
- Fairness: req0 re-asserted immediately after each done, req2 constant → grants alternate 0, 2, 0, 2; req2 never waits more than one operation.
- Stale ready: mul_ready left high after the previous op and the model takes 3 cycles to drop and re-raise → no premature done; result taken from the fresh edge.
- Timeout: model never raises ready, TIMEOUT=64 → done pulses 65 cycles after mul_start; res_out=0x7FC00000; err=1 and stays 1. The next request then completes normally.
- Reset in WAIT: rst=0 two cycles after mul_start → done, mul_start and err all 0 asynchronously; the FSM is in IDLE after release and rr pointer=0.
